// File: rtl/decode_pkg.sv
// Shared encodings for the RV32IM decode stage: ALU/immediate/result codes,
// opcodes, the registered control bundle and the stage FSM states.
package decode_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_LSL   = 4'd5;
    localparam logic [3:0] ALU_LSR   = 4'd6;
    localparam logic [3:0] ALU_ASR   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_B  = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;
    localparam logic [2:0] IMM_I5 = 3'd5;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       muldiv;
        logic       sys;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_TRAP    = 2'd2
    } state_t;

    // funct3 -> ALU op for register and immediate arithmetic
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_LSL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_ASR : ALU_LSR;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32IM instruction -> control bundle decoder.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;
    logic       legal_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];

    // Field extraction and per-opcode control generation
    always_comb begin
        ctrl        = '0;
        ctrl.rd     = instr[11:7];
        ctrl.rs1    = instr[19:15];
        ctrl.rs2    = instr[24:20];
        ctrl.funct3 = f3_s;
        legal_s     = 1'b1;
        case (opcode_s)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case (f7_s)
                    7'h00: ctrl.alu_ctrl = alu_op(f3_s, 1'b0);
                    7'h20: begin
                        if (f3_s == 3'd0 || f3_s == 3'd5) ctrl.alu_ctrl = alu_op(f3_s, 1'b1);
                        else legal_s = 1'b0;
                    end
                    7'h01: begin
                        if (EN_MULDIV) ctrl.muldiv = 1'b1;
                        else legal_s = 1'b0;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_op(f3_s, 1'b0);
                ctrl.imm_src   = IMM_I;
                if (f3_s == 3'd1) begin
                    ctrl.imm_src = IMM_I5;
                    legal_s      = (f7_s == 7'h00);
                end else if (f3_s == 3'd5) begin
                    ctrl.imm_src  = IMM_I5;
                    ctrl.alu_ctrl = alu_op(f3_s, f7_s[5]);
                    legal_s       = (f7_s == 7'h00) || (f7_s == 7'h20);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
                case (f3_s)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_s = 1'b1;
                    default:                      legal_s = 1'b0;
                endcase
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                legal_s        = (f3_s == 3'd0) || (f3_s == 3'd1) || (f3_s == 3'd2);
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.imm_src = IMM_B;
                case (f3_s)
                    3'd0, 3'd1: ctrl.alu_ctrl = ALU_SUB;
                    3'd4, 3'd5: ctrl.alu_ctrl = ALU_SLT;
                    3'd6, 3'd7: ctrl.alu_ctrl = ALU_SLTU;
                    default:    legal_s = 1'b0;
                endcase
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = RES_PC4;
                ctrl.reg_write  = 1'b1;
            end
            OP_JALR: begin
                ctrl.jalr       = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.reg_write  = 1'b1;
                legal_s         = (f3_s == 3'd0);
            end
            OP_LUI: begin
                ctrl.alu_ctrl  = ALU_PASSB;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.imm_src   = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_SYSTEM: begin
                // only ecall (all-zero) and ebreak (imm=1) are decoded
                ctrl.sys = 1'b1;
                legal_s  = (instr[31:7] == 25'h0000000) || (instr[31:7] == 25'h0002000);
            end
            default: legal_s = 1'b0;
        endcase
        // class flags are cleared too, so an illegal word can never start a mul/div stall
        if (!legal_s) begin
            ctrl.illegal   = 1'b1;
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
            ctrl.jalr      = 1'b0;
            ctrl.muldiv    = 1'b0;
            ctrl.sys       = 1'b0;
        end else begin
            ctrl.reg_write = ctrl.reg_write & (instr[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: registers the decoded control bundle behind a
// valid/ready handshake, blocks issue after mul/div and traps on illegal words.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MULDIV_CYCLES = 32,
    parameter bit EN_MULDIV     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [3:0]            ALUctrl,
    output logic                  ALUsrc,
    output logic [2:0]            ImmSrc,
    output logic [1:0]            ResultSrc,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  branch,
    output logic                  jump,
    output logic                  jalr,
    output logic                  muldiv,
    output logic                  sys,
    output logic [2:0]            funct3_o,
    output logic                  illegal
);

    localparam int              CNT_W    = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    ctrl_t                   dec_s;
    ctrl_t                   ctrl_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   pc_r;
    logic                    capture_s;
    logic                    out_hs_s;

    decode_comb #(.EN_MULDIV(EN_MULDIV)) u_decode_comb (
        .instr (instr[31:0]),
        .ctrl  (dec_s)
    );

    // rst_n gates in_ready so it reads 0 while reset is held
    assign in_ready  = rst_n && (state_r == ST_RUN) && (!out_valid_r || out_ready) && !flush;
    assign capture_s = in_valid && in_ready;
    assign out_hs_s  = out_valid_r && out_ready;

    // Pipeline register, handshake and RUN/MD_BUSY/TRAP sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            cnt_r       <= '0;
            ctrl_r      <= '0;
            out_valid_r <= 1'b0;
            pc_r        <= '0;
        end else begin
            if (capture_s) begin
                ctrl_r <= dec_s;
                pc_r   <= pc;
            end
            if (flush) begin
                out_valid_r <= 1'b0;
                state_r     <= ST_RUN;
                cnt_r       <= '0;
            end else begin
                if (capture_s) out_valid_r <= 1'b1;
                else if (out_hs_s) out_valid_r <= 1'b0;
                case (state_r)
                    ST_RUN: begin
                        if (out_hs_s && ctrl_r.muldiv) begin
                            state_r <= ST_MD_BUSY;
                            cnt_r   <= CNT_LOAD;
                        end else if (capture_s && dec_s.illegal) begin
                            state_r <= ST_TRAP;
                        end
                    end
                    ST_MD_BUSY: begin
                        // a mul captured while the previous one left restarts the window;
                        // an illegal word captured in that same cycle traps once it expires
                        if (out_hs_s && ctrl_r.muldiv) cnt_r <= CNT_LOAD;
                        else if (cnt_r == '0) state_r <= ctrl_r.illegal ? ST_TRAP : ST_RUN;
                        else cnt_r <= cnt_r - CNT_W'(1);
                    end
                    ST_TRAP: state_r <= ST_TRAP;
                    default: state_r <= ST_RUN;
                endcase
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_pc    = pc_r;
    assign rd        = ctrl_r.rd;
    assign rs1       = ctrl_r.rs1;
    assign rs2       = ctrl_r.rs2;
    assign ALUctrl   = ctrl_r.alu_ctrl;
    assign ALUsrc    = ctrl_r.alu_src;
    assign ImmSrc    = ctrl_r.imm_src;
    assign ResultSrc = ctrl_r.result_src;
    assign RegWrite  = ctrl_r.reg_write;
    assign MemWrite  = ctrl_r.mem_write;
    assign branch    = ctrl_r.branch;
    assign jump      = ctrl_r.jump;
    assign jalr      = ctrl_r.jalr;
    assign muldiv    = ctrl_r.muldiv;
    assign sys       = ctrl_r.sys;
    assign funct3_o  = ctrl_r.funct3;
    assign illegal   = ctrl_r.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised successor to the single-cycle control decoder for the RV32IM pipeline.
- Decodes one instruction per cycle into a registered control bundle, using a valid/ready handshake on both sides.
- Supports flush, and stalls issue for the multi-cycle M-extension ops.
- Flags illegal encodings and holds in a trap state until flushed.
- Branch resolution (PCsrc) moves out of this block and into execute; this block emits the branch condition only.

Parameters:
- DATA_WIDTH, 32, instruction/PC width.
- MULDIV_CYCLES, 32, cycles issue is blocked after a mul/div leaves the stage (≥1).
- EN_MULDIV, 1, 1 = decode M extension; 0 = funct7 01h in R-type is illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  stage accepts this cycle.
- instr  in  DATA_WIDTH  instruction word.
- pc  in  DATA_WIDTH  instruction address.
- flush  in  1  discard held/incoming instruction, leave trap.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  DATA_WIDTH  registered pc.
- rd, rs1, rs2  out  5 each  register indices.
- ALUctrl  out  4  ALU op (package codes).
- ALUsrc  out  1  1 = immediate operand.
- ImmSrc  out  3  immediate format.
- ResultSrc  out  2  0 ALU, 1 memory, 2 PC+4.
- RegWrite, MemWrite  out  1 each.
- branch, jump, jalr, muldiv, sys  out  1 each  instruction class.
- funct3_o  out  3  branch condition / load-store size / muldiv op.
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset: all outputs 0; state RUN; counter 0.
- Pipeline register:
  - in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
  - Capture on in_valid && in_ready; the bundle appears next cycle with out_valid=1.
  - Latency 1 cycle.
- Backpressure: while out_valid && !out_ready, every output is held bit-stable.
- Handshake ordering: out_valid drops the cycle after an out handshake unless a new capture happens in the same cycle. Back-to-back throughput is 1/cycle.
- Decode rules:
  - R-type: ALUsrc 0, RegWrite 1.
  - OP-IMM: ALUsrc 1, ImmSrc I. slli/srli/srai use ImmSrc I5; the shift funct7 must be 00h or 20h (srai only), otherwise illegal.
  - Load: ResultSrc 1, ImmSrc I, ADD.
  - Store: MemWrite 1, RegWrite 0, ImmSrc S, ADD.
  - Branch: branch 1, ImmSrc B, RegWrite 0. beq/bne use SUB; blt/bge use SLT; bltu/bgeu use SLTU. Condition is on funct3_o.
  - jal: jump 1, ImmSrc J, ResultSrc 2, RegWrite 1.
  - jalr: jalr 1, ImmSrc I, ALUsrc 1, ResultSrc 2, RegWrite 1.
  - lui: ALUctrl PASSB, ImmSrc U.
  - auipc: ADD, ImmSrc U, ALUsrc 1.
  - ecall/ebreak: sys 1, RegWrite 0.
  - mul/div (EN_MULDIV): muldiv 1, RegWrite 1.
  - Unlisted opcode/funct combinations: illegal 1, with RegWrite and MemWrite forced to 0.
- RegWrite is forced to 0 when rd==0.
- FSM:
  - RUN: an out handshake carrying muldiv=1 goes to MD_BUSY with counter=MULDIV_CYCLES-1. A capture of an illegal instruction goes to TRAP.
  - MD_BUSY: in_ready=0. Counter decrements each cycle; at 0 return to RUN on the next cycle. Total blocked cycles = MULDIV_CYCLES.
  - TRAP: the illegal bundle is presented normally. After it is accepted, out_valid stays 0 and in_ready stays 0 until flush.
- Flush has priority over all other events:
  - Next cycle: out_valid=0, state RUN, counter cleared.
  - Any instruction offered in the flush cycle is not captured.
- Simultaneous events:
  - Flush together with an out handshake: the handshake completes.
  - Flush in MD_BUSY: busy is aborted; execute owns cancellation of its own mul/div.
- Reset asserted mid-operation (any state): immediate return to reset values.

Decomposition:
- Package decode_pkg holds:
  - ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, LSL 5, LSR 6, ASR 7, SLT 8, SLTU 9, PASSB 10.
  - ImmSrc codes: I 0, S 1, B 2, U 3, J 4, I5 5.
  - ResultSrc codes.
  - Opcode constants.
  - Control-bundle packed struct typedef.
  - FSM state enum.
- Sub-module decode_comb: a purely combinational instr → bundle decoder. decode_stage wraps it with the register, handshake and FSM.

Test Plan:
- add x3,x1,x2 (0x002081B3), in_valid=1, out_ready=1 → next cycle: out_valid=1, ALUctrl=0, RegWrite=1, ALUsrc=0, rd=3, rs1=1, rs2=2. Then sub (0x402081B3) back-to-back → ALUctrl=1 on the following cycle.
- beq x1,x2,+8 (0x00208463) → branch=1, funct3_o=000, ImmSrc=2, ALUctrl=1, RegWrite=0. With out_ready=0 for 3 cycles, outputs stay identical and in_ready=0.
- mul (0x022081B3) with MULDIV_CYCLES=4 → muldiv=1. After the out handshake, in_ready=0 for exactly 4 cycles, then 1. Repeat with EN_MULDIV=0 → illegal=1.
- 0xFFFFFFFF → illegal=1, RegWrite=0, MemWrite=0. After acceptance, in_ready=0 indefinitely; flush pulse → in_ready=1 the next cycle.
- addi x0,x0,5 (0x00500013) → RegWrite=0. lui x5,0x12345 (0x123452B7) → ALUctrl=10, ImmSrc=3, RegWrite=1.
- Deassert rst_n asynchronously in MD_BUSY and with out_valid=1 → all outputs 0 immediately. After release, in_ready=1.
